pipe_stage_hs: RTL and testbench

Parametrised ready/valid pipeline-stage register for the CoreCpu pipeline, generalising the fixed stall-only stage latches such as MEM→WB. It carries the addr/data/rd/control bundle of one stage with per-entry valid, synchronous flush and optional 2-entry skid buffering. Backpressure can then come from a slow consumer (dcache, WB port arbitration) without a global combinational stall net. A saturating backpressure counter feeds the performance counters.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/sat_counter.sv | 28 ++
 rtl/pipe_stage_hs.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_hs.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for CoreCpu ready/valid pipeline stages: bubble encoding, stage
// occupancy states and the default-width stage bundle.
package pipe_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefRdW   = 5;
  localparam int unsigned DefCtrlW = 4;

  // Control value of a bubble: no architectural side effect.
  localparam int unsigned BubbleCtrl = 0;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stage_state_t;

  // Default-width view of a stage bundle. Stages with other widths declare
  // the same field layout locally from their own parameters.
  typedef struct packed {
    logic [DefDataW-1:0] addr;
    logic [DefDataW-1:0] data;
    logic [DefRdW-1:0]   rd;
    logic [DefCtrlW-1:0] ctrl;
  } stage_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Ready/valid pipeline-stage register with optional skid entry, synchronous
// flush, bubble masking of out_ctrl and a saturating backpressure counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bp_cycles
);

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } bundle_t;

  stage_state_t state_q, state_d;
  bundle_t      main_q, main_d;
  bundle_t      skid_q;
  bundle_t      in_bundle;
  logic         load_skid;
  logic         in_xfer, out_xfer;
  logic         bp_inc;

  assign in_bundle = '{addr: in_addr, data: in_data, rd: in_rd, ctrl: in_ctrl};
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload clears on reset only so outputs read as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
    end else begin
      main_q <= main_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    load_skid = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          state_d = StOne;
          main_d  = in_bundle;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_d = in_bundle;
        end else if (in_xfer) begin
          state_d   = StFull;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_xfer) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Only the valid state matters on flush; stale payload is masked.
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    out_valid = (state_q != StEmpty);
    out_addr  = main_q.addr;
    out_data  = main_q.data;
    out_rd    = main_q.rd;
    out_ctrl  = out_valid ? main_q.ctrl : CTRL_W'(BubbleCtrl);
  end

  if (SKID != 0) begin : gen_skid
    bundle_t skid_d;

    always_comb begin
      skid_d = skid_q;
      if (load_skid) begin
        skid_d = in_bundle;
      end
    end

    always_ff @(posedge clk) begin
      skid_q <= skid_d;
    end

    // Registered ready: no combinational path from out_ready.
    assign in_ready = (state_q != StFull);
  end else begin : gen_no_skid
    logic unused_load_skid;

    assign skid_q           = '0;
    assign unused_load_skid = load_skid;
    assign in_ready         = (state_q == StEmpty) || out_ready;
  end

  assign bp_inc = out_valid && !out_ready;

  sat_counter #(
    .W(CNT_W)
  ) u_bp_counter (
    .clk  (clk),
    .inc  (bp_inc),
    .clr  (rst),
    .count(bp_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench: a skid stage (4-bit counter) and a single-entry stage share
// one stimulus stream; each accepted input is queued and checked on output.
module tb_pipe_stage_hs;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  typedef logic [DW+DW+RW+CW-1:0] bun_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic [RW-1:0] in_rd = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_addr1, out_data1, out_addr0, out_data0;
  logic [RW-1:0] out_rd1, out_rd0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [3:0]    bp1;
  logic [15:0]   bp0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out0 = 0;
  int   idx, guard;
  bun_t q1[$];
  bun_t q0[$];

  pipe_stage_hs #(
    .DATA_W(DW), .RD_W(RW), .CTRL_W(CW), .SKID(1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_addr(in_addr), .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_addr(out_addr1),
    .out_data(out_data1), .out_rd(out_rd1), .out_ctrl(out_ctrl1), .bp_cycles(bp1)
  );

  pipe_stage_hs #(
    .DATA_W(DW), .RD_W(RW), .CTRL_W(CW), .SKID(0), .CNT_W(16)
  ) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_addr(in_addr), .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_addr(out_addr0),
    .out_data(out_data0), .out_rd(out_rd0), .out_ctrl(out_ctrl0), .bp_cycles(bp0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input bun_t act, input bun_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = 32'hD000_0000 | a;
    in_rd    = a[4:0];
    in_ctrl  = {1'b1, a[2:0]};
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Monitor: pop on output transfers, then drop on flush or push accepted inputs.
  always @(negedge clk) begin
    bun_t e;
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          fail_now("sb1_unexpected_output");
        end else begin
          e = q1.pop_front();
          chk("sb1_bundle", {out_addr1, out_data1, out_rd1, out_ctrl1}, e);
        end
      end
      if (out_valid0 && out_ready) begin
        n_out0++;
        if (q0.size() == 0) begin
          fail_now("sb0_unexpected_output");
        end else begin
          e = q0.pop_front();
          chk("sb0_bundle", {out_addr0, out_data0, out_rd0, out_ctrl0}, e);
        end
      end
      if (flush) begin
        q1.delete();
        q0.delete();
      end else if (in_valid) begin
        if (in_ready1) q1.push_back({in_addr, in_data, in_rd, in_ctrl});
        if (in_ready0) q0.push_back({in_addr, in_data, in_rd, in_ctrl});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out_addr", out_addr1, 0);
    chk("rst_out_data", out_data1, 0);
    chk("rst_out_rd", out_rd1, 0);
    chk("rst_out_ctrl", out_ctrl1, 0);
    chk("rst_bp", bp1, 0);
    chk("rst_in_ready", in_ready1, 1);
    chk("rst_in_ready0", in_ready0, 1);
    chk("rst_out_valid0", out_valid0, 0);

    // Stream four bundles with no backpressure.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h10 + i);
      #1;
      chk("stream_in_ready", in_ready1, 1);
      if (i > 0) chk("stream_latency_addr", out_addr1, 32'h10 + i - 1);
      step();
    end
    idle();
    #1;
    chk("stream_last_addr", out_addr1, 32'h13);
    step();
    chk("stream_drained", out_valid1, 0);
    chk("stream_bp", bp1, 0);

    // Backpressure into the skid entry.
    out_ready = 1'b0;
    send(32'h20);
    #1;
    chk("bp_a_ready", in_ready1, 1);
    step();
    send(32'h21);
    #1;
    chk("bp_b_ready", in_ready1, 1);
    step();
    send(32'h22);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_full_ready", in_ready1, 0);
      chk("bp_head_addr", out_addr1, 32'h20);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_count_stalls", bp1, 4);
    chk("bp_still_full", in_ready1, 0);
    step();
    chk("bp_ready_after_drain", in_ready1, 1);
    chk("bp_b_addr", out_addr1, 32'h21);
    step();
    idle();
    #1;
    chk("bp_c_addr", out_addr1, 32'h22);
    step();
    chk("bp_done_valid", out_valid1, 0);
    chk("bp_count_hold", bp1, 4);

    // Flush while full with a live input.
    out_ready = 1'b0;
    send(32'h30);
    step();
    send(32'h31);
    step();
    send(32'h32);
    flush = 1'b1;
    #1;
    chk("flush_pre_bp", bp1, 5);
    step();
    flush = 1'b0;
    idle();
    #1;
    chk("flush_out_valid", out_valid1, 0);
    chk("flush_out_ctrl", out_ctrl1, 0);
    chk("flush_in_ready", in_ready1, 1);
    chk("flush_keeps_bp", bp1, 6);
    chk("flush_out_valid0", out_valid0, 0);
    step();
    chk("flush_no_capture", out_valid1, 0);

    // Reset while full.
    send(32'h40);
    step();
    send(32'h41);
    step();
    send(32'h42);
    rst = 1'b1;
    #1;
    chk("rst_mid_full", in_ready1, 0);
    step();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_mid_valid", out_valid1, 0);
    chk("rst_mid_addr", out_addr1, 0);
    chk("rst_mid_data", out_data1, 0);
    chk("rst_mid_rd", out_rd1, 0);
    chk("rst_mid_ctrl", out_ctrl1, 0);
    chk("rst_mid_bp", bp1, 0);
    chk("rst_mid_ready", in_ready1, 1);
    out_ready = 1'b1;
    send(32'h50);
    step();
    idle();
    #1;
    chk("post_rst_first_valid", out_valid1, 1);
    chk("post_rst_first_addr", out_addr1, 32'h50);
    step();
    chk("post_rst_drained", out_valid1, 0);

    // Counter saturation on the 4-bit instance.
    out_ready = 1'b0;
    chk("sat_start", bp1, 0);
    send(32'h60);
    step();
    idle();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) begin
        chk("sat_mid", bp1, 10);
        chk("wide_mid", bp0, 10);
      end
    end
    chk("sat_top", bp1, 15);
    chk("wide_top", bp0, 20);
    out_ready = 1'b1;
    step();
    step();
    step();

    // Single-entry stage: alternating out_ready, 32 bundles held until accepted.
    n_out0 = 0;
    idx = 0;
    guard = 0;
    while (idx < 32 && guard < 200) begin
      out_ready = ~out_ready;
      send(32'h100 + idx);
      #1;
      if (out_valid0) chk("noskid_ready_follows", in_ready0, out_ready);
      else chk("noskid_ready_empty", in_ready0, 1);
      if (in_ready0) idx++;
      guard++;
      step();
    end
    if (guard >= 200) fail_now("noskid_timeout");
    idle();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("noskid_count", n_out0, 32);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
